// File: rtl/uart_csr_bank_pkg.sv
// Purpose: shared definitions for the UART CSR bank: register indices,
//          STATUS bit positions, the CTRL field layout, the W1C mask and
//          the reset constants.
package uart_csr_bank_pkg;

   localparam int unsigned REG_IDX_W = 3;

   // Per-channel register indices (low address bits)
   localparam logic [REG_IDX_W-1:0] REG_BAUD     = 3'd0;
   localparam logic [REG_IDX_W-1:0] REG_CTRL     = 3'd1;
   localparam logic [REG_IDX_W-1:0] REG_STATUS   = 3'd2;
   localparam logic [REG_IDX_W-1:0] REG_IRQ_EN   = 3'd3;
   localparam logic [REG_IDX_W-1:0] REG_PERR_CNT = 3'd4;

   // STATUS bit positions
   localparam int unsigned ST_BUSY = 0;
   localparam int unsigned ST_DBE  = 1;
   localparam int unsigned ST_PERR = 2;
   localparam int unsigned ST_OVR  = 3;

   // Sticky flags occupy STATUS[3:1]; all of them are write-1-to-clear
   localparam logic [3:1] STATUS_W1C_MASK = 3'b111;

   localparam logic [31:0] BAUD_RST_DEF = 32'd434;
   localparam logic [31:0] CTRL_RST_DEF = 32'h0000_0008;

   // Low byte of CTRL
   typedef struct packed {
      logic       en;
      logic       stop;
      logic [1:0] parity;
      logic [3:0] data_bits;
   } uart_ctrl_t;

   // Legal character lengths are 5..8 bits
   function automatic logic data_bits_bad(input logic [3:0] db);
      return (db < 4'd5) || (db > 4'd8);
   endfunction

endpackage

// File: rtl/uart_csr_channel.sv
// Purpose: register set for one UART channel: BAUD, CTRL, sticky W1C STATUS
//          flags, IRQ_EN, saturating parity-error counter and interrupt.
// Ports:   clk/rst        clock, synchronous active-high reset
//          wen_i/idx_i/wdata_i  decoded write for this channel
//          busy_i/par_err_i/ovr_i  engine status and event pulses
//          baud_o/ctrl_o/status_o/irq_en_o/perr_cnt_o  register read words
//          irq_o          registered channel interrupt
module uart_csr_channel
   import uart_csr_bank_pkg::*;
#(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       CNT_W    = 8,
   parameter logic [DATA_W-1:0] BAUD_RST = DATA_W'(BAUD_RST_DEF),
   parameter logic [DATA_W-1:0] CTRL_RST = DATA_W'(CTRL_RST_DEF)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wen_i,
   input  logic [REG_IDX_W-1:0] idx_i,
   input  logic [DATA_W-1:0]    wdata_i,
   input  logic                 busy_i,
   input  logic                 par_err_i,
   input  logic                 ovr_i,
   output logic [DATA_W-1:0]    baud_o,
   output logic [DATA_W-1:0]    ctrl_o,
   output logic [DATA_W-1:0]    status_o,
   output logic [DATA_W-1:0]    irq_en_o,
   output logic [DATA_W-1:0]    perr_cnt_o,
   output logic                 irq_o
);

   logic [DATA_W-1:0] baud_q;
   logic [DATA_W-1:8] ctrl_hi_q;
   uart_ctrl_t        ctrl_lo_q;
   logic              busy_q;
   logic [3:1]        flag_q, flag_d, set_c, clr_c;
   logic [3:1]        irq_en_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              irq_q;

   logic wr_baud_c, wr_ctrl_c, wr_status_c, wr_irq_en_c, wr_cnt_c;

   assign wr_baud_c   = wen_i && (idx_i == REG_BAUD);
   assign wr_ctrl_c   = wen_i && (idx_i == REG_CTRL);
   assign wr_status_c = wen_i && (idx_i == REG_STATUS);
   assign wr_irq_en_c = wen_i && (idx_i == REG_IRQ_EN);
   assign wr_cnt_c    = wen_i && (idx_i == REG_PERR_CNT);

   // Flag and counter next-state: set wins over a same-cycle clear
   always_comb begin
      set_c          = '0;
      set_c[ST_DBE]  = ctrl_lo_q.en && data_bits_bad(ctrl_lo_q.data_bits);
      set_c[ST_PERR] = par_err_i;
      set_c[ST_OVR]  = ovr_i;
      clr_c          = wr_status_c ? (wdata_i[3:1] & STATUS_W1C_MASK) : '0;
      flag_d         = (flag_q & ~clr_c) | set_c;

      cnt_d = cnt_q;
      if (wr_cnt_c) cnt_d = '0;
      if (par_err_i && (cnt_d != {CNT_W{1'b1}})) cnt_d = cnt_d + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_q    <= BAUD_RST;
         ctrl_hi_q <= CTRL_RST[DATA_W-1:8];
         ctrl_lo_q <= uart_ctrl_t'(CTRL_RST[7:0]);
         busy_q    <= 1'b0;
         flag_q    <= '0;
         irq_en_q  <= '0;
         cnt_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (wr_baud_c) baud_q <= wdata_i;
         if (wr_ctrl_c) begin
            ctrl_hi_q <= wdata_i[DATA_W-1:8];
            ctrl_lo_q <= uart_ctrl_t'(wdata_i[7:0]);
         end
         if (wr_irq_en_c) irq_en_q <= wdata_i[3:1];
         busy_q <= busy_i;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
         // Interrupt trails the flags by one cycle
         irq_q  <= |(flag_q & irq_en_q);
      end
   end

   assign baud_o     = baud_q;
   assign ctrl_o     = {ctrl_hi_q, ctrl_lo_q};
   assign status_o   = DATA_W'({flag_q, busy_q});
   assign irq_en_o   = DATA_W'({irq_en_q, 1'b0});
   assign perr_cnt_o = DATA_W'(cnt_q);
   assign irq_o      = irq_q;

endmodule

// File: rtl/uart_csr_bank.sv
// Purpose: multi-channel UART CSR bank: address decode, per-channel register
//          sets, registered read port and address-error pulse.
// Ports:   clk/rst            clock, synchronous active-high reset
//          wr_addr/wr_data/wen  write port, address {channel, reg_idx}
//          rd_addr/ren        read port; rd_data/rd_valid one cycle later
//          addr_err           pulse for accesses to channels >= NUM_CH
//          baud_o/ctrl_o      per-channel configuration, packed by channel
//          ch_busy_i/ch_par_err_i/ch_ovr_i  engine status and events
//          irq_o/irq_any_o    per-channel interrupts and their OR
module uart_csr_bank
   import uart_csr_bank_pkg::*;
#(
   parameter int unsigned       NUM_CH   = 4,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       CH_W     = 4,
   parameter logic [DATA_W-1:0] BAUD_RST = DATA_W'(BAUD_RST_DEF),
   parameter logic [DATA_W-1:0] CTRL_RST = DATA_W'(CTRL_RST_DEF),
   parameter int unsigned       CNT_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH_W+2:0]          wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wen,
   input  logic [CH_W+2:0]          rd_addr,
   input  logic                     ren,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     addr_err,
   output logic [NUM_CH*DATA_W-1:0] baud_o,
   output logic [NUM_CH*DATA_W-1:0] ctrl_o,
   input  logic [NUM_CH-1:0]        ch_busy_i,
   input  logic [NUM_CH-1:0]        ch_par_err_i,
   input  logic [NUM_CH-1:0]        ch_ovr_i,
   output logic [NUM_CH-1:0]        irq_o,
   output logic                     irq_any_o
);

   logic [CH_W-1:0]      wr_ch_c, rd_ch_c;
   logic [REG_IDX_W-1:0] wr_idx_c, rd_idx_c;
   logic                 wr_ok_c, rd_ok_c;

   assign wr_ch_c  = wr_addr[CH_W+2:3];
   assign wr_idx_c = wr_addr[2:0];
   assign rd_ch_c  = rd_addr[CH_W+2:3];
   assign rd_idx_c = rd_addr[2:0];
   assign wr_ok_c  = 32'(wr_ch_c) < NUM_CH;
   assign rd_ok_c  = 32'(rd_ch_c) < NUM_CH;

   logic [DATA_W-1:0] baud_w [NUM_CH];
   logic [DATA_W-1:0] ctrl_w [NUM_CH];
   logic [DATA_W-1:0] stat_w [NUM_CH];
   logic [DATA_W-1:0] ien_w  [NUM_CH];
   logic [DATA_W-1:0] cnt_w  [NUM_CH];

   // One register set per channel; out-of-range writes reach none of them
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic wen_ch_c;
      assign wen_ch_c = wen && wr_ok_c && (wr_ch_c == CH_W'(g));

      uart_csr_channel #(
         .DATA_W   (DATA_W),
         .CNT_W    (CNT_W),
         .BAUD_RST (BAUD_RST),
         .CTRL_RST (CTRL_RST)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .wen_i      (wen_ch_c),
         .idx_i      (wr_idx_c),
         .wdata_i    (wr_data),
         .busy_i     (ch_busy_i[g]),
         .par_err_i  (ch_par_err_i[g]),
         .ovr_i      (ch_ovr_i[g]),
         .baud_o     (baud_w[g]),
         .ctrl_o     (ctrl_w[g]),
         .status_o   (stat_w[g]),
         .irq_en_o   (ien_w[g]),
         .perr_cnt_o (cnt_w[g]),
         .irq_o      (irq_o[g])
      );

      assign baud_o[g*DATA_W +: DATA_W] = baud_w[g];
      assign ctrl_o[g*DATA_W +: DATA_W] = ctrl_w[g];
   end

   // Read mux; invalid channels and reserved indices yield zero
   logic [DATA_W-1:0] rd_word_c;
   always_comb begin
      rd_word_c = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch_c == CH_W'(c)) begin
            case (rd_idx_c)
               REG_BAUD:     rd_word_c = baud_w[c];
               REG_CTRL:     rd_word_c = ctrl_w[c];
               REG_STATUS:   rd_word_c = stat_w[c];
               REG_IRQ_EN:   rd_word_c = ien_w[c];
               REG_PERR_CNT: rd_word_c = cnt_w[c];
               default:      rd_word_c = '0;
            endcase
         end
      end
   end

   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              addr_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= ren;
         if (ren) rd_data_q <= rd_word_c;
         // Single pulse even when both strobes miss
         addr_err_q <= (wen && !wr_ok_c) || (ren && !rd_ok_c);
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign addr_err  = addr_err_q;
   assign irq_any_o = |irq_o;

endmodule
